// File: rtl/right_shifter_seq.sv
// Iterative 32-bit right shifter: the shift count is resolved in three radix stages, one per cycle.
// Optional feature macro: RSHIFT_ROR_EN adds the rot port and rotate-right mode.
module right_shifter_seq #(
    parameter bit BYPASS_ZERO = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] x,
    input  logic [4:0]  sc,
    input  logic        md,
`ifdef RSHIFT_ROR_EN
    input  logic        rot,
`endif
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] y
);

    typedef enum logic [2:0] {StIdle, StS0, StS1, StS2, StDone} state_e;

    state_e      state_q;
    logic [31:0] acc_q, acc_d;
    logic [4:0]  sc_q;
    logic        fill_q;
    logic        rot_q;
    logic        in_ready_q, out_valid_q;
    logic [4:0]  amt;
    logic [31:0] upper;

    // Every stage shifts the 64-bit pair {upper, acc}: upper is the fill word or acc itself (rotate).
    always_comb begin
        amt = 5'd0;
        unique case (state_q)
            StS0:    amt = {3'b000, sc_q[1:0]};
            StS1:    amt = {1'b0, sc_q[3:2], 2'b00};
            StS2:    amt = {sc_q[4], 4'b0000};
            default: amt = 5'd0;
        endcase
        upper = rot_q ? acc_q : {32{fill_q}};
        acc_d = 32'({upper, acc_q} >> amt);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            acc_q       <= 32'd0;
            sc_q        <= 5'd0;
            fill_q      <= 1'b0;
`ifdef RSHIFT_ROR_EN
            rot_q       <= 1'b0;
`endif
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        acc_q      <= x;
                        sc_q       <= sc;
                        fill_q     <= md & x[31];
`ifdef RSHIFT_ROR_EN
                        rot_q      <= rot;
`endif
                        in_ready_q <= 1'b0;
                        if (BYPASS_ZERO && (sc == 5'd0)) begin
                            state_q     <= StDone;
                            out_valid_q <= 1'b1;
                        end else begin
                            state_q <= StS0;
                        end
                    end
                end
                StS0: begin
                    acc_q   <= acc_d;
                    state_q <= StS1;
                end
                StS1: begin
                    acc_q   <= acc_d;
                    state_q <= StS2;
                end
                StS2: begin
                    acc_q       <= acc_d;
                    state_q     <= StDone;
                    out_valid_q <= 1'b1;
                end
                StDone: begin
                    if (out_ready) begin
                        state_q     <= StIdle;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= StIdle;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                end
            endcase
        end
    end

`ifndef RSHIFT_ROR_EN
    assign rot_q = 1'b0;
`endif

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign y         = acc_q;

endmodule

// File: tb/tb_right_shifter_seq.sv
// Bench for right_shifter_seq: directed cases plus randomized ops checked against an arithmetic model.
// Two instances run side by side, one with the zero-count bypass and one without.
module tb_right_shifter_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        iv = 1'b0;
    logic        sel = 1'b0;
    logic [31:0] x = 32'd0;
    logic [4:0]  sc = 5'd0;
    logic        md = 1'b0;
    logic        rot = 1'b0;
    logic        out_ready = 1'b0;

    logic        in_valid0, in_valid1, in_ready0, in_ready1, out_valid0, out_valid1;
    logic [31:0] y0, y1;
    logic        cur_ir, cur_ov;
    logic [31:0] cur_y;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign in_valid0 = iv && !sel;
    assign in_valid1 = iv && sel;
    assign cur_ir    = sel ? in_ready1 : in_ready0;
    assign cur_ov    = sel ? out_valid1 : out_valid0;
    assign cur_y     = sel ? y1 : y0;

    right_shifter_seq #(.BYPASS_ZERO(1'b1)) u_dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid0), .in_ready(in_ready0),
        .x(x), .sc(sc), .md(md),
`ifdef RSHIFT_ROR_EN
        .rot(rot),
`endif
        .out_valid(out_valid0), .out_ready(out_ready), .y(y0)
    );

    right_shifter_seq #(.BYPASS_ZERO(1'b0)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
        .x(x), .sc(sc), .md(md),
`ifdef RSHIFT_ROR_EN
        .rot(rot),
`endif
        .out_valid(out_valid1), .out_ready(out_ready), .y(y1)
    );

    function automatic logic [31:0] ref_y(input logic [31:0] xv, input logic [4:0] s,
                                          input logic m, input logic r);
        if (r) return (s == 5'd0) ? xv : ((xv >> s) | (xv << (32 - int'(s))));
        if (m) return 32'($signed(xv) >>> s);
        return xv >> s;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full transaction on instance d; garbage keeps in_valid high with changing operands while busy.
    task automatic do_op(input logic d, input logic [31:0] xv, input logic [4:0] scv,
                         input logic mdv, input logic rotv, input logic [31:0] exp_y,
                         input int bp, input logic garbage);
        int k;
        int exp_lat;
        sel = d;
        for (int n = 0; n < 20 && !cur_ir; n++) step();
        check("in_ready_idle", 32'(cur_ir), 32'd1);
        x = xv; sc = scv; md = mdv; rot = rotv; iv = 1'b1;
        step();
        iv = garbage;
        x = $urandom; sc = 5'($urandom); md = 1'($urandom);
        k = 0;
        while (!cur_ov && k < 20) begin
            check("in_ready_busy", 32'(cur_ir), 32'd0);
            step();
            k++;
            x = $urandom; sc = 5'($urandom); md = 1'($urandom);
        end
        iv = 1'b0;
        exp_lat = (d == 1'b0 && scv == 5'd0) ? 1 : 4;
        check("latency", 32'(k + 1), 32'(exp_lat));
        check("y", cur_y, exp_y);
        for (int i = 0; i < bp; i++) begin
            step();
            check("bp_y", cur_y, exp_y);
            check("bp_out_valid", 32'(cur_ov), 32'd1);
            check("bp_in_ready", 32'(cur_ir), 32'd0);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("drain_out_valid", 32'(cur_ov), 32'd0);
        check("drain_in_ready", 32'(cur_ir), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rx;
        logic [4:0]  rs;
        logic        rm, rr, rd;

        step();
        step();
        rst = 1'b0;
        check("rst_in_ready0", 32'(in_ready0), 32'd1);
        check("rst_out_valid0", 32'(out_valid0), 32'd0);
        check("rst_y0", y0, 32'd0);
        check("rst_in_ready1", 32'(in_ready1), 32'd1);
        check("rst_out_valid1", 32'(out_valid1), 32'd0);
        check("rst_y1", y1, 32'd0);

        do_op(1'b0, 32'h12345678, 5'd4, 1'b0, 1'b0, 32'h01234567, 5, 1'b1);
        do_op(1'b1, 32'h12345678, 5'd4, 1'b0, 1'b0, 32'h01234567, 0, 1'b0);
        do_op(1'b0, 32'h80000000, 5'd31, 1'b0, 1'b0, 32'h00000001, 0, 1'b0);
        do_op(1'b0, 32'h80000000, 5'd31, 1'b1, 1'b0, 32'hFFFFFFFF, 1, 1'b0);
        do_op(1'b1, 32'hF0000000, 5'd0, 1'b1, 1'b0, 32'hF0000000, 0, 1'b1);
        do_op(1'b0, 32'hF0000000, 5'd0, 1'b0, 1'b0, 32'hF0000000, 2, 1'b1);
        do_op(1'b1, 32'h8F0F0F0F, 5'd13, 1'b1, 1'b0, 32'hFFFC7878, 0, 1'b0);

        // Abort mid-operation: after reset nothing from the aborted op may surface.
        sel = 1'b1;
        x = 32'hDEADBEEF; sc = 5'd7; md = 1'b1; iv = 1'b1;
        step();
        iv = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("abort_in_ready", 32'(in_ready1), 32'd1);
        check("abort_out_valid", 32'(out_valid1), 32'd0);
        check("abort_y", y1, 32'd0);
        for (int i = 0; i < 5; i++) begin
            step();
            check("abort_no_stale", 32'(out_valid1), 32'd0);
        end

`ifdef RSHIFT_ROR_EN
        do_op(1'b0, 32'h12345678, 5'd8, 1'b1, 1'b1, 32'h78123456, 0, 1'b0);
        do_op(1'b1, 32'h00000001, 5'd31, 1'b0, 1'b1, 32'h00000002, 0, 1'b0);
`endif

        for (int t = 0; t < 40; t++) begin
            rx = $urandom;
            rs = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom);
            rm = 1'($urandom);
            rd = 1'($urandom);
`ifdef RSHIFT_ROR_EN
            rr = 1'($urandom);
`else
            rr = 1'b0;
`endif
            do_op(rd, rx, rs, rm, rr, ref_y(rx, rs, rm, rr), $urandom_range(0, 3),
                  1'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
